// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett result resolver: FSM states, chunk-count helper, defaults.
package barrett_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_N       = 1024;
  localparam int DEF_M_DIG   = 4;
  localparam int DEF_W       = 64;
  localparam int DEF_MAX_SUB = 4;

  function automatic int calcChunks(input int l, input int w);
    return (l + w - 1) / w;
  endfunction

endpackage

// File: rtl/barrett_chunk_addsub.sv
// One W-bit chunk of the serial datapath: add with carry-in, or subtract (B inverted) with borrow-in.
module barrett_chunk_addsub #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_bOp;
  logic         w_cinOp;
  logic [W:0]   w_full;

  // In subtract mode i_cin/o_cout carry borrow semantics: A - B - bin = A + ~B + ~bin.
  assign w_bOp   = i_sub ? ~i_b : i_b;
  assign w_cinOp = i_sub ? ~i_cin : i_cin;
  assign w_full  = {1'b0, i_a} + {1'b0, w_bOp} + {{W{1'b0}}, w_cinOp};
  assign o_sum   = w_full[W-1:0];
  assign o_cout  = i_sub ? ~w_full[W] : w_full[W];

endmodule

// File: rtl/barrett_resolve.sv
// Resolves a carry-save Barrett result chunk-serially and reduces it by repeated subtraction of MOD.
// Define BARRETT_RESOLVE_ERR_EN to add the err port flagging an exceeded reduction bound.
module barrett_resolve
  import barrett_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int M_DIG   = DEF_M_DIG,
  parameter int W       = DEF_W,
  parameter int MAX_SUB = DEF_MAX_SUB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N+M_DIG+11:0]   ZS,
  input  logic [N+M_DIG+11:0]   ZC,
  input  logic [N-1:0]          MOD,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          Z
`ifdef BARRETT_RESOLVE_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int L     = N + M_DIG + 12;
  localparam int C     = calcChunks(L, W);
  localparam int CW    = C * W;
  localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
  localparam int K_W   = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;

  state_t           r_state;
  state_t           w_nextState;
  logic [CW-1:0]    r_zs;
  logic [CW-1:0]    r_zc;
  logic [CW-1:0]    r_mod;
  logic [CW-1:0]    r_v;
  logic [CW-1:0]    r_shadow;
  logic [CW-1:0]    w_shadowNext;
  logic [CW-1:0]    w_lmask;
  logic [CNT_W-1:0] r_cnt;
  logic [K_W-1:0]   r_k;
  logic             r_cb;
  logic             r_outValid;
  logic [N-1:0]     r_z;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic [W-1:0]     w_sum;
  logic             w_cout;
  logic             w_sub;
  logic             w_lastChunk;
  logic             w_accept;
  logic             w_passOk;
  logic             w_atMax;
`ifdef BARRETT_RESOLVE_ERR_EN
  logic             r_err;
`endif

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_outValid;
  assign Z           = r_z;
  assign w_accept    = in_valid && in_ready;
  assign w_sub       = (r_state == SUB);
  assign w_lastChunk = (r_cnt == CNT_W'(C - 1));
  assign w_passOk    = ~w_cout;
  assign w_atMax     = (r_k == K_W'(MAX_SUB));
  assign w_a         = w_sub ? r_v[r_cnt*W +: W]   : r_zs[r_cnt*W +: W];
  assign w_b         = w_sub ? r_mod[r_cnt*W +: W] : r_zc[r_cnt*W +: W];
`ifdef BARRETT_RESOLVE_ERR_EN
  assign err         = r_err;
`endif

  barrett_chunk_addsub #(.W(W)) u_chunk (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_cin  (r_cb),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Bits at or above L belong to the zero-padded top chunk and must stay clear for V mod 2^L.
  always_comb begin
    w_lmask = '0;
    for (int i = 0; i < CW; i++) w_lmask[i] = (i < L);
  end

  always_comb begin
    w_shadowNext = r_shadow;
    w_shadowNext[r_cnt*W +: W] = w_sum;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = ADD;
      ADD:     if (w_lastChunk) w_nextState = SUB;
      SUB:     if (w_lastChunk && (!w_passOk || w_atMax)) w_nextState = DONE;
      DONE:    if (r_outValid && out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Once k hits MAX_SUB the final pass only checks; its difference is never committed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_zs       <= '0;
      r_zc       <= '0;
      r_mod      <= '0;
      r_v        <= '0;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_cb       <= 1'b0;
      r_outValid <= 1'b0;
      r_z        <= '0;
`ifdef BARRETT_RESOLVE_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_zs  <= CW'(ZS);
            r_zc  <= CW'(ZC);
            r_mod <= CW'(MOD);
            r_cnt <= '0;
            r_cb  <= 1'b0;
            r_k   <= '0;
`ifdef BARRETT_RESOLVE_ERR_EN
            r_err <= 1'b0;
`endif
          end
        end
        ADD: begin
          r_v[r_cnt*W +: W] <= w_sum & w_lmask[r_cnt*W +: W];
          if (w_lastChunk) begin
            r_cnt <= '0;
            r_cb  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_cb  <= w_cout;
          end
        end
        SUB: begin
          if (w_lastChunk) begin
            r_cnt <= '0;
            r_cb  <= 1'b0;
            if (w_passOk && !w_atMax) begin
              r_v <= w_shadowNext;
              r_k <= r_k + 1'b1;
            end
`ifdef BARRETT_RESOLVE_ERR_EN
            if (w_passOk && w_atMax) r_err <= 1'b1;
`endif
          end else begin
            r_shadow[r_cnt*W +: W] <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            r_cb  <= w_cout;
          end
        end
        DONE: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_z        <= r_v[N-1:0];
          end else if (out_ready) begin
            r_outValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/barrett_resolve.md
BARRETT_RESOLVE -- requirements
Module: barrett_resolve

Interface
REQ-001 SHALL have parameter N, default 1024: modulus width in bits.
REQ-002 SHALL have parameter M_DIG, default 4: radix digit width of the producing iteration step; the redundant operand width is L = N+M_DIG+12.
REQ-003 SHALL have parameter W, default 64: chunk width; C = ceil(L/W) chunks, and the top chunk is zero-padded.
REQ-004 SHALL have parameter MAX_SUB, default 4: maximum number of conditional subtractions of MOD.
REQ-005 CLK  input  1  clock; all state is updated on the rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  ZS, ZC and MOD are valid.
REQ-008 in_ready  output  1  block accepts an operand set.
REQ-009 ZS  input  L  redundant sum word.
REQ-010 ZC  input  L  redundant carry word.
REQ-011 MOD  input  N  modulus.
REQ-012 out_valid  output  1  Z is valid.
REQ-013 out_ready  input  1  consumer accepts Z.
REQ-014 Z  output  N  fully reduced binary result.
REQ-015 err  output  1  reduction bound exceeded; the port is present only when BARRETT_RESOLVE_ERR_EN is defined.

Function
REQ-016 SHALL implement the FSM states IDLE, ADD, SUB and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; an accept is in_valid&&in_ready at edge t0, which captures ZS, ZC and MOD and moves the FSM to ADD.
REQ-018 ADD SHALL compute V=(ZS+ZC) mod 2^L at one W-bit chunk per cycle, LSB chunk first, with the carry registered between chunks; it takes C cycles and the carry out of the top chunk is discarded.
REQ-019 Each SUB pass SHALL compute V-MOD, with MOD zero-extended to L bits, chunk-serially over C cycles with the borrow registered between chunks; the difference is held in a shadow register.
REQ-020 At the end of a pass, no borrow SHALL mean V is replaced by the difference, the subtraction count k is incremented, and another pass starts; a borrow SHALL mean V is unchanged and the FSM moves to DONE.
REQ-021 When k reaches MAX_SUB, exactly one further check pass SHALL run; the FSM then moves to DONE, and a no-borrow result in that pass sets err (ERR_EN builds only).
REQ-022 The number of passes P SHALL be k+1; out_valid SHALL rise at edge t0+C*(1+P)+1.
REQ-023 In DONE, out_valid=1 and Z=V[N-1:0]; Z and err SHALL remain stable until out_valid&&out_ready.
REQ-024 Output handshake: on out_valid&&out_ready the FSM SHALL return to IDLE and in_ready=1 from the next cycle; no accept may occur in the same cycle as the output handshake.
REQ-025 With MOD=0 every pass has no borrow, so the block SHALL run MAX_SUB+1 passes and set err.
REQ-026 Input signals SHALL be ignored outside the accept cycle; operand changes while busy SHALL have no effect.

Reset
REQ-027 RST low SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, Z=0, err=0, k=0, and clear all carry/borrow and chunk counters.
REQ-028 Reset mid-ADD, mid-SUB or during DONE SHALL abort the operation with no output handshake.

Configuration
REQ-029 With BARRETT_RESOLVE_ERR_EN defined, the err port and its detection logic SHALL be present, with err cleared on the next accept.
REQ-030 Without BARRETT_RESOLVE_ERR_EN, the err port SHALL be absent; the FSM still stops after MAX_SUB+1 passes and Z is the truncated V.

Structure
REQ-031 Shared package barrett_pkg SHALL hold the state enum, the function computing C from L and W, and the default parameter constants.
REQ-032 SHALL use one sub-module, barrett_chunk_addsub: a W-bit adder with carry-in and a sub control that inverts B; it returns sum and carry/borrow out.
REQ-033 Chunk selection SHALL use a log2(C)-bit chunk counter and a shift-register or indexed-slice datapath; there SHALL be no full-width L-bit carry chain.

Verification (N=8, M_DIG=4 so L=24; W=8 so C=3; MAX_SUB=4)
REQ-034 ZS=0x000010, ZC=0x00000F, MOD=0x0B: V=31, k=2, P=3 -> Z=0x09, out_valid at t0+13, err=0.
REQ-035 ZS=0x000005, ZC=0x000000, MOD=0x0B: no subtraction, P=1 -> Z=0x05, out_valid at t0+7.
REQ-036 ZS=0x0000FF, ZC=0x000001, MOD=0xFF: V=0x100 crosses a chunk carry, k=1 -> Z=0x01, out_valid at t0+10.
REQ-037 ZS=0x00001F, ZC=0, MOD=0x01: P=5, out_valid at t0+19 -> ERR_EN build gives Z=0x1B, err=1; non-ERR build gives Z=0x1B.
REQ-038 Hold out_ready=0 for 5 cycles after out_valid -> Z stays stable and in_ready=0; out_ready=1 -> IDLE, then a second operand set is accepted one cycle later.
REQ-039 Assert RST at t0+5 of the REQ-034 case -> out_valid=0 immediately; after release, in_ready=1 and a fresh run matches REQ-034.
